// File: rtl/sub_4bit_serial.sv
// rtl/sub_4bit_serial.sv - bit-serial WIDTH-bit subtractor with borrow, LSB first
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset
//   start in   request one subtraction (sampled only in IDLE)
//   a     in   minuend [WIDTH-1:0]
//   b     in   subtrahend [WIDTH-1:0]
//   bin   in   borrow-in
//   d     out  difference register [WIDTH-1:0]
//   bout  out  borrow-out register
//   busy  out  high in SHIFT and DONE
//   done  out  one-cycle pulse when d and bout are final
module sub_4bit_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             brw_q, brw_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic bit_a;
    logic bit_b;
    logic brw_nxt;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        brw_d   = brw_q;
        d_d     = d_q;
        bout_d  = bout_q;

        bit_a   = a_q[cnt_q];
        bit_b   = b_q[cnt_q];
        brw_nxt = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & brw_q);

        case (state_q)
            IDLE: begin
                // d and bout keep the previous result until the first bit is processed
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    brw_d   = bin;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                d_d[cnt_q] = bit_a ^ bit_b ^ brw_q;
                brw_d      = brw_nxt;
                if (cnt_q == LAST_BIT) begin
                    bout_d  = brw_nxt;
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status flags are registered from the next state so they line up with state_q
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            brw_q   <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            brw_q   <= brw_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign d    = d_q;
    assign bout = bout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_sub_4bit_serial.sv
// tb/tb_sub_4bit_serial.sv - self-checking bench for sub_4bit_serial
module tb_sub_4bit_serial;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [3:0] d;
    logic       bout;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    sub_4bit_serial #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .d     (d),
        .bout  (bout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       bin;
        logic [3:0] ed;
        logic       eb;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands
    function automatic logic [4:0] ref_sub(input logic [3:0] ra, input logic [3:0] rb, input logic rbin);
        int diff;
        diff = int'(ra) - int'(rb) - int'(rbin);
        ref_sub = {(diff < 0), 4'(diff & 15)};
    endfunction

    // Accept edge counts as edge 1; returns the edge number at which done was seen,
    // plus the done/busy state one edge later. Operand inputs are scrambled mid-operation.
    task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_, input logic tbin,
                          output logic [3:0] rd, output logic rbout, output int lat,
                          output logic post_done, output logic post_busy);
        @(negedge clk);
        a = ta; b = tb_; bin = tbin; start = 1'b1;
        @(posedge clk);
        lat = 1;
        #1;
        start = 1'b0;
        a = 4'($urandom); b = 4'($urandom); bin = 1'($urandom);
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
            if (done) break;
            a = 4'($urandom); b = 4'($urandom); bin = 1'($urandom);
        end
        rd    = d;
        rbout = bout;
        @(posedge clk);
        #1;
        post_done = done;
        post_busy = busy;
    endtask

    vec_t       tbl [5];
    logic [3:0] rd;
    logic       rb;
    int         lat;
    logic       pd, pb;
    logic [4:0] exp_r;
    logic [8:0] ops [36];
    int         done_cnt;
    int         seen;

    initial begin
        tbl[0] = '{a: 4'd9,  b: 4'd5,  bin: 1'b0, ed: 4'd4,  eb: 1'b0};
        tbl[1] = '{a: 4'd3,  b: 4'd5,  bin: 1'b0, ed: 4'd14, eb: 1'b1};
        tbl[2] = '{a: 4'd0,  b: 4'd0,  bin: 1'b1, ed: 4'd15, eb: 1'b1};
        tbl[3] = '{a: 4'd15, b: 4'd15, bin: 1'b1, ed: 4'd15, eb: 1'b1};
        tbl[4] = '{a: 4'd15, b: 4'd0,  bin: 1'b0, ed: 4'd15, eb: 1'b0};

        void'($urandom(1919));

        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        #1;
        check("reset_d",    32'(d),    32'd0);
        check("reset_bout", 32'(bout), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed vectors
        for (int i = 0; i < 5; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].bin, rd, rb, lat, pd, pb);
            check($sformatf("vec%0d_d", i),       32'(rd), 32'(tbl[i].ed));
            check($sformatf("vec%0d_bout", i),    32'(rb), 32'(tbl[i].eb));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd5);
            check($sformatf("vec%0d_done_pulse", i), 32'(pd), 32'd0);
            check($sformatf("vec%0d_busy_after", i), 32'(pb), 32'd0);
        end

        // Result holds in IDLE while inputs wander
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a = 4'($urandom); b = 4'($urandom); bin = 1'($urandom);
        end
        #1;
        check("hold_d",    32'(d),    32'd15);
        check("hold_bout", 32'(bout), 32'd0);

        // start held high, operands change every cycle: accepts every 6 edges
        done_cnt = 0;
        for (int k = 0; k < 36; k++) begin
            @(negedge clk);
            a = 4'($urandom); b = 4'($urandom); bin = 1'($urandom); start = 1'b1;
            ops[k] = {bin, b, a};
            @(posedge clk);
            #1;
            if (done) begin
                done_cnt++;
                check($sformatf("b2b_done_edge%0d", k), 32'(k % 6), 32'd4);
                if (k >= 4) begin
                    exp_r = ref_sub(ops[k-4][3:0], ops[k-4][7:4], ops[k-4][8]);
                    check($sformatf("b2b_result_edge%0d", k), 32'({bout, d}), 32'(exp_r));
                end
            end
        end
        check("b2b_done_count", 32'(done_cnt), 32'd6);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);

        // Reset during the second SHIFT cycle
        @(negedge clk);
        a = 4'd12; b = 4'd3; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_d",    32'(d),    32'd0);
        check("abort_bout", 32'(bout), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        run_op(4'd12, 4'd7, 1'b1, rd, rb, lat, pd, pb);
        check("after_abort_d",       32'(rd),  32'd4);
        check("after_abort_bout",    32'(rb),  32'd0);
        check("after_abort_latency", 32'(lat), 32'd5);

        // Random operand sets against the arithmetic reference
        for (int i = 0; i < 200; i++) begin
            logic [3:0] ra, rbb;
            logic       rbin;
            ra = 4'($urandom); rbb = 4'($urandom); rbin = 1'($urandom);
            run_op(ra, rbb, rbin, rd, rb, lat, pd, pb);
            exp_r = ref_sub(ra, rbb, rbin);
            check($sformatf("rand%0d_result a=%0d b=%0d bin=%0d", i, ra, rbb, rbin),
                  32'({rb, rd}), 32'(exp_r));
            check($sformatf("rand%0d_latency", i), 32'(lat), 32'd5);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
